// File: rtl/yolo_stream_pkg.sv
// Shared definitions for the YOLO activation stream paths.
// Provides the default beat width, the layer13 packet length and the
// state type used by the stream arbiters.
package yolo_stream_pkg;

    // 8 x int8 activations per beat
    localparam int STREAM_DATA_W     = 64;

    // Beats per packet produced by the layer13 LeakyReLU stage
    localparam int LAYER13_PKT_BEATS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Registered output stage for a valid/ready write stream.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   load                             - capture load_data/load_last/load_src this cycle
//   load_data, load_last, load_src   - beat to capture
//   m_ready                          - downstream accepts the held beat
//   out_free                         - register can take a new beat this cycle
//   m_data, m_valid, m_last, m_src   - registered beat presented downstream
module stream_out_reg
    import yolo_stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_src,
    input  logic              m_ready,
    output logic              out_free,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              m_src
);

    // The register is free when empty or when its beat leaves this cycle,
    // which lets a full-rate stream pass with a single stage.
    assign out_free = !m_valid || m_ready;

    // A load wins over a drain so back-to-back beats keep m_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_src   <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_last  <= load_last;
            m_src   <= load_src;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/leakyrelu_stream_arbiter.sv
// Packet-granular round-robin merge of two LeakyReLU output streams onto
// the single write stream feeding the output DMA.
// Ports:
//   sclk, s_rst_n                         - clock, asynchronous active-low reset
//   s0_data/valid/last, s0_ready          - source 0 stream
//   s1_data/valid/last, s1_ready          - source 1 stream
//   m_data/valid/last/src, m_ready        - merged registered stream, tagged by source
//   err_len                               - one-cycle pulse on a packet length error
//   pkt_cnt                               - completed packet count (wraps)
module leakyrelu_stream_arbiter
    import yolo_stream_pkg::*;
#(
    parameter int DATA_W    = STREAM_DATA_W,
    parameter int PKT_BEATS = LAYER13_PKT_BEATS
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              m_src,
    input  logic              m_ready,
    output logic              err_len,
    output logic [15:0]       pkt_cnt
);

    localparam logic [8:0] PKT_LEN = 9'(PKT_BEATS);

    arb_state_t        state, state_next;
    logic              rr_ptr;
    logic [7:0]        beat_cnt;
    logic              long_flag;
    logic              out_free;
    logic              accept;
    logic              acc_src;
    logic              acc_last;
    logic [DATA_W-1:0] acc_data;
    logic [8:0]        cnt_inc;
    logic              len_err;

    // Grant selection and beat steering. Ready depends only on the state and
    // the output register, never on the sources' valid.
    always_comb begin
        state_next = state;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        accept     = 1'b0;
        acc_src    = 1'b0;
        acc_last   = 1'b0;
        acc_data   = s0_data;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_next = rr_ptr ? BUSY1 : BUSY0;
                end else if (s0_valid) begin
                    state_next = BUSY0;
                end else if (s1_valid) begin
                    state_next = BUSY1;
                end
            end
            BUSY0: begin
                s0_ready = out_free;
                accept   = s0_valid && out_free;
                acc_last = s0_last;
                if (accept && s0_last) begin
                    state_next = IDLE;
                end
            end
            BUSY1: begin
                s1_ready = out_free;
                accept   = s1_valid && out_free;
                acc_src  = 1'b1;
                acc_last = s1_last;
                acc_data = s1_data;
                if (accept && s1_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Flag a beat beyond the expected length once, and a last beat that lands
    // on the wrong count, unless this packet has already been flagged as long.
    assign cnt_inc = {1'b0, beat_cnt} + 9'd1;
    assign len_err = accept && !long_flag &&
                     (({1'b0, beat_cnt} >= PKT_LEN) || (acc_last && (cnt_inc != PKT_LEN)));

    // State, round-robin pointer and packet bookkeeping. Every packet starts
    // from IDLE, so clearing the beat counter there covers entry to BUSYn.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            beat_cnt  <= 8'd0;
            long_flag <= 1'b0;
            err_len   <= 1'b0;
            pkt_cnt   <= 16'd0;
        end else begin
            state   <= state_next;
            err_len <= len_err;
            if (state == IDLE) begin
                beat_cnt  <= 8'd0;
                long_flag <= 1'b0;
            end else if (accept) begin
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (len_err) begin
                    long_flag <= 1'b1;
                end
                if (acc_last) begin
                    rr_ptr  <= !acc_src;
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
            end
        end
    end

    stream_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (sclk),
        .rst_n     (s_rst_n),
        .load      (accept),
        .load_data (acc_data),
        .load_last (acc_last),
        .load_src  (acc_src),
        .m_ready   (m_ready),
        .out_free  (out_free),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_src     (m_src)
    );

endmodule

// File: tb/tb_leakyrelu_stream_arbiter.sv
// Scoreboard bench for leakyrelu_stream_arbiter: packets are planned per
// source, a packet-level round-robin model orders the expected beats, and a
// monitor compares every beat leaving the merged stream.
module tb_leakyrelu_stream_arbiter;
    import yolo_stream_pkg::*;

    localparam int DW = STREAM_DATA_W;
    localparam int PB = LAYER13_PKT_BEATS;

    logic          sclk;
    logic          s_rst_n;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_valid, s0_last, s0_ready;
    logic          s1_valid, s1_last, s1_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, m_src, m_ready;
    logic          err_len;
    logic [15:0]   pkt_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } src_beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          src;
        logic          err;
        int            idx;
    } exp_beat_t;

    src_beat_t drv_q0[$];
    src_beat_t drv_q1[$];
    exp_beat_t exp_q[$];
    int        plen0[$];
    int        plen1[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int model_rr     = 0;
    int exp_pkts     = 0;
    int cyc          = 0;
    int hs_count     = 0;
    int ready_mode   = 0;
    bit gap_check    = 0;
    int last_end_cyc = -1;

    leakyrelu_stream_arbiter #(
        .DATA_W    (DW),
        .PKT_BEATS (PB)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_src    (m_src),
        .m_ready  (m_ready),
        .err_len  (err_len),
        .pkt_cnt  (pkt_cnt)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Turn the planned packet lengths into source beats and, using a
    // packet-level round-robin model, into the expected merged sequence.
    task automatic applyStimulus(input bit idx_data);
        int        i0, i1, len;
        bit        src;
        src_beat_t sb;
        exp_beat_t eb;
        i0 = 0;
        i1 = 0;
        while (i0 < plen0.size() || i1 < plen1.size()) begin
            if (i0 < plen0.size() && i1 < plen1.size()) src = (model_rr != 0);
            else                                        src = (i1 < plen1.size());
            if (src) begin len = plen1[i1]; i1++; end
            else     begin len = plen0[i0]; i0++; end
            for (int b = 0; b < len; b++) begin
                sb.data = idx_data ? DW'(b) : {$urandom(), $urandom()};
                sb.last = (b == len - 1);
                eb.data = sb.data;
                eb.last = sb.last;
                eb.src  = src;
                eb.idx  = b;
                if (len > PB)      eb.err = (b == PB);
                else if (len < PB) eb.err = (b == len - 1);
                else               eb.err = 1'b0;
                if (src) drv_q1.push_back(sb);
                else     drv_q0.push_back(sb);
                exp_q.push_back(eb);
            end
            model_rr = src ? 0 : 1;
            exp_pkts++;
        end
        plen0.delete();
        plen1.delete();
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || drv_q0.size() > 0 || drv_q1.size() > 0) && n < budget) begin
            @(posedge sclk);
            n++;
        end
        checkOutput("drain_pending_beats", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge sclk);
        @(negedge sclk);
    endtask

    // Asynchronous reset a little after an edge; outputs must clear at once.
    task automatic doReset();
        @(posedge sclk);
        #2;
        s_rst_n = 1'b0;
        drv_q0.delete();
        drv_q1.delete();
        exp_q.delete();
        model_rr     = 0;
        exp_pkts     = 0;
        last_end_cyc = -1;
        #1;
        checkOutput("rst_m_valid",  64'(m_valid),  64'd0);
        checkOutput("rst_m_last",   64'(m_last),   64'd0);
        checkOutput("rst_m_src",    64'(m_src),    64'd0);
        checkOutput("rst_m_data",   64'(m_data),   64'd0);
        checkOutput("rst_err_len",  64'(err_len),  64'd0);
        checkOutput("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
        checkOutput("rst_s0_ready", 64'(s0_ready), 64'd0);
        checkOutput("rst_s1_ready", 64'(s1_ready), 64'd0);
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        #1;
        s_rst_n = 1'b1;
    endtask

    // Source drivers: valid stays high while beats are queued; a beat is
    // retired once the mid-cycle sample shows a handshake.
    initial begin : drv0
        bit fire;
        s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
        forever begin
            @(negedge sclk);
            fire = s0_valid && s0_ready;
            @(posedge sclk);
            #1;
            if (fire && drv_q0.size() > 0) void'(drv_q0.pop_front());
            if (drv_q0.size() > 0) begin
                s0_valid = 1'b1; s0_data = drv_q0[0].data; s0_last = drv_q0[0].last;
            end else begin
                s0_valid = 1'b0; s0_last = 1'b0;
            end
        end
    end

    initial begin : drv1
        bit fire;
        s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
        forever begin
            @(negedge sclk);
            fire = s1_valid && s1_ready;
            @(posedge sclk);
            #1;
            if (fire && drv_q1.size() > 0) void'(drv_q1.pop_front());
            if (drv_q1.size() > 0) begin
                s1_valid = 1'b1; s1_data = drv_q1[0].data; s1_last = drv_q1[0].last;
            end else begin
                s1_valid = 1'b0; s1_last = 1'b0;
            end
        end
    end

    initial begin : rdy
        m_ready = 1'b0;
        forever begin
            @(posedge sclk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = !m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples mid-cycle, checks stall stability, the err_len pulse
    // on each beat's first cycle, and every handshaken beat against the queue.
    initial begin : monitor
        logic          pv, phs, pl, ps, cur_err;
        logic [DW-1:0] pd;
        bit            first;
        exp_beat_t     e;
        pv = 1'b0; phs = 1'b0; pl = 1'b0; ps = 1'b0; cur_err = 1'b0; pd = '0;
        forever begin
            @(negedge sclk);
            cyc++;
            if (!s_rst_n) begin
                pv  = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (m_valid) begin
                first = !pv || phs;
                if (first) begin
                    cur_err = err_len;
                end else begin
                    checkOutput("stall_data", 64'(m_data), 64'(pd));
                    checkOutput("stall_ctrl", 64'({m_last, m_src}), 64'({pl, ps}));
                    if (err_len) checkOutput("stray_err_len", 64'(err_len), 64'd0);
                end
                if (m_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 64'(m_data), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", 64'(m_data), 64'(e.data));
                        checkOutput("beat_last", 64'(m_last), 64'(e.last));
                        checkOutput("beat_src",  64'(m_src),  64'(e.src));
                        checkOutput("beat_err",  64'(cur_err), 64'(e.err));
                        if (gap_check && e.idx == 0 && last_end_cyc >= 0)
                            checkOutput("pkt_gap", 64'(cyc - last_end_cyc), 64'd2);
                        if (e.last) last_end_cyc = cyc;
                    end
                end
            end else if (err_len) begin
                checkOutput("stray_err_len", 64'(err_len), 64'd0);
            end
            pv  = m_valid;
            phs = m_valid && m_ready;
            pd  = m_data;
            pl  = m_last;
            ps  = m_src;
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int t0, dur, start, n;
        s_rst_n = 1'b0;
        doReset();

        // Single source, data = beat index
        ready_mode = 0;
        plen0.push_back(PB);
        applyStimulus(1'b1);
        waitDrain(200);
        checkOutput("single_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));

        // Contention from reset: 0,1,0,1 with one idle cycle between packets
        doReset();
        gap_check = 1'b1;
        plen0.push_back(PB); plen0.push_back(PB);
        plen1.push_back(PB); plen1.push_back(PB);
        applyStimulus(1'b0);
        waitDrain(400);
        gap_check = 1'b0;
        checkOutput("contention_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // Backpressure: m_ready toggling every cycle
        ready_mode = 1;
        plen0.push_back(PB);
        t0 = cyc;
        applyStimulus(1'b0);
        waitDrain(300);
        dur = last_end_cyc - t0;
        checkOutput("bp_duration_about_64", 64'(dur >= 60 && dur <= 72), 64'd1);
        checkOutput("bp_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));

        // Short packet on s1 competing with s0; round robin decides order
        ready_mode = 2;
        plen1.push_back(21);
        plen0.push_back(PB);
        applyStimulus(1'b0);
        waitDrain(500);
        checkOutput("short_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));

        // Long packet on s0
        plen0.push_back(40);
        plen1.push_back(PB);
        applyStimulus(1'b0);
        waitDrain(500);
        checkOutput("long_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));

        // Random packet mixes with random backpressure
        for (int r = 0; r < 4; r++) begin
            int k0, k1;
            k0 = $urandom_range(0, 2);
            k1 = $urandom_range(0, 2);
            if (k0 + k1 == 0) k0 = 1;
            for (int i = 0; i < k0; i++) plen0.push_back($urandom_range(1, 40));
            for (int i = 0; i < k1; i++) plen1.push_back($urandom_range(1, 40));
            applyStimulus(1'b0);
            waitDrain(1000);
        end
        checkOutput("random_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));

        // Reset in the middle of a packet, then s1 alone is granted
        ready_mode = 0;
        plen0.push_back(PB);
        start = hs_count;
        applyStimulus(1'b0);
        n = 0;
        while (hs_count - start < 10 && n < 100) begin
            @(posedge sclk);
            n++;
        end
        checkOutput("midpkt_reached_beat10", 64'(hs_count - start >= 10), 64'd1);
        doReset();
        plen1.push_back(PB);
        applyStimulus(1'b0);
        waitDrain(200);
        checkOutput("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/leakyrelu_stream_arbiter.md
# leakyrelu_stream_arbiter

Packet-granular round-robin arbiter that merges two 64-bit LeakyReLU output streams (e.g. the layer13 branch and the upsample/route branch) onto the single write stream feeding the output DMA. A grant is held for a whole packet, up to and including its `last` beat. Every outgoing beat is tagged with its source. Each packet's beat count is checked against the configured length.

## Interface
Parameters:
- `DATA_W`, 64: beat width; 8 × int8 activations per beat.
- `PKT_BEATS`, 32: expected beats per packet, range 1..255.

Ports:
- `sclk`, in, 1: system clock; single clock domain.
- `s_rst_n`, in, 1: asynchronous, active-low reset.
- `s0_data`, in, DATA_W: source 0 beat.
- `s0_valid`, in, 1: source 0 beat valid.
- `s0_last`, in, 1: source 0 final beat of packet.
- `s0_ready`, out, 1: source 0 beat accepted when `s0_valid & s0_ready`.
- `s1_data`, `s1_valid`, `s1_last`, `s1_ready`: source 1; same widths and rules as source 0.
- `m_data`, out, DATA_W: merged beat (registered).
- `m_valid`, out, 1: merged beat valid.
- `m_last`, out, 1: merged final beat of packet.
- `m_src`, out, 1: source index of the current beat.
- `m_ready`, in, 1: downstream accepts beat when `m_valid & m_ready`.
- `err_len`, out, 1: one-cycle pulse when a packet's length is wrong.
- `pkt_cnt`, out, 16: count of completed packets; wraps at 65535 → 0.

## Operation
- FSM states: IDLE, BUSY0, BUSY1.
- IDLE:
  - Both `s*_ready` = 0.
  - Only s0_valid → BUSY0; only s1_valid → BUSY1.
  - Both valid → go to the source selected by the `rr_ptr` register (0 = source 0).
  - Neither valid → stay in IDLE.
- BUSYn:
  - `sn_ready` = `out_free`; the other source's ready = 0.
  - `out_free` = `!m_valid | m_ready`.
  - Each accepted beat loads the output register: `m_data`, `m_last`, `m_src` = n, and `m_valid` = 1.
- On acceptance of a beat with `sn_last` = 1:
  - Return to IDLE.
  - `rr_ptr` ← !n.
  - `pkt_cnt` increments.
- Output register:
  - If `m_ready` = 1 and no new beat is accepted, `m_valid` ← 0.
  - Otherwise the output register holds its contents.
- Length check:
  - `beat_cnt` (8 bit) counts accepted beats in the current packet.
  - It saturates at 255 and clears on entry to BUSYn.
  - On the accepted last beat, `err_len` pulses if `beat_cnt+1` != PKT_BEATS.
  - The packet is still forwarded intact and terminated by the source's `last`.
  - A beat accepted after PKT_BEATS beats without `last` also pulses `err_len`, once per packet.
- Data is passed unmodified; no arithmetic on the payload.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_src`=0, `m_data`=0, `err_len`=0, `pkt_cnt`=0, `rr_ptr`=0, state=IDLE, `beat_cnt`=0, `s*_ready`=0.
- Latency: beat accepted at edge k appears on `m_*` after edge k.
- Throughput: 1 beat/cycle while `m_ready`=1.
- Inter-packet gap: one IDLE cycle between packets, so 33 cycles per 32-beat packet.
- Ready path: `s*_ready` is combinational from `m_valid`, `m_ready` and state; there is no path from `s*_valid` to `s*_ready`.
- Backpressure: while `m_valid & !m_ready`, `m_*` is stable and no source is accepted.
- Mid-packet requests: a request from the other source while in BUSYn is ignored until n's `last` is accepted.
- `err_len` timing: asserted the cycle after the offending beat is accepted, concurrent with that beat on `m_*`.
- Reset mid-packet: all state clears immediately. A partial packet on `m_*` is dropped. No `last` is generated.

## Structure
- Shared package `yolo_stream_pkg`:
  - `STREAM_DATA_W` = 64.
  - `LAYER13_PKT_BEATS` = 32.
  - State enum type `arb_state_t`.
- One natural sub-module, `stream_out_reg`: the pipeline output register with `out_free` logic, reusable by the other layer tx paths.
- The FSM, round-robin pointer and counters stay in the top module.

## Test plan
- **Single source:** s0 sends a 32-beat packet with data = beat index, `m_ready`=1. Required: 32 beats on `m_*` with `m_src`=0 and `m_last` on beat 31 only, then `pkt_cnt`=1 and `err_len` never asserts.
- **Contention:** s0 and s1 both valid from reset, 2 packets each. Required: packet order 0,1,0,1; no interleaving within a packet; `pkt_cnt`=4; one-cycle gap between packets.
- **Backpressure:** `m_ready` toggles 1/0 every cycle. Required:
  - `m_data` stable across every stall cycle.
  - No beat duplicated or lost; compare against a scoreboard.
  - Completion takes about 64 cycles.
- **Short packet:** s1 asserts `last` on beat 20. Required: one `err_len` pulse concurrent with beat 20 on `m_*`; packet forwarded; next grant follows the round-robin order.
- **Long packet:** s0 sends 40 beats with `last` on beat 39. Required: exactly one `err_len` pulse, at beat 32; all 40 beats forwarded.
- **Reset mid-packet:** `s_rst_n` low at beat 10. Required: all outputs at reset values within the same cycle; after release, s1's packet is granted first (`rr_ptr`=0 → source 0 only if s0 is valid).
